fifo_ctrl: RTL and testbench

Control stage for the synchronous FIFO. It owns the write pointer, the read pointer and the occupancy count, and drives the up/down enable and mode inputs of those counters. It produces the dual-port RAM write/read addresses and strobes, plus FULL/EMPTY/USE_DW status. It sits between the FIFO user interface (WRITE/READ requests) and the RAM plus counter datapath.

---
 rtl/fifo_ctrl_if.sv | 36 +++
 rtl/fifo_ctrl.sv | 120 ++++++++++++
 tb/tb_fifo_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ctrl_if
//  Description : User request / RAM strobe / status bundle of the FIFO
//                control stage. The slave modport is the controller's view,
//                the master modport is the user-side view.
//  Revision    : 1.0  initial release
// ============================================================================
interface fifo_ctrl_if #(
   parameter int ADDR_WIDTH = 5
);
   logic                  WRITE;
   logic                  READ;
   logic                  RAM_WE;
   logic                  RAM_RE;
   logic [ADDR_WIDTH-1:0] RAM_WADDR;
   logic [ADDR_WIDTH-1:0] RAM_RADDR;
   logic                  FULL;
   logic                  EMPTY;
   logic [ADDR_WIDTH:0]   USE_DW;
   logic                  OVERFLOW;
   logic                  UNDERFLOW;

   modport slave (
      input  WRITE, READ,
      output RAM_WE, RAM_RE, RAM_WADDR, RAM_RADDR,
      output FULL, EMPTY, USE_DW, OVERFLOW, UNDERFLOW
   );

   modport master (
      output WRITE, READ,
      input  RAM_WE, RAM_RE, RAM_WADDR, RAM_RADDR,
      input  FULL, EMPTY, USE_DW, OVERFLOW, UNDERFLOW
   );
endinterface
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ctrl
//  Description : Synchronous FIFO control stage. Owns the write/read pointers
//                and the occupancy counter, accepts user requests against the
//                current FULL/EMPTY state and drives the dual-port RAM strobes
//                and addresses plus status and overflow/underflow pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_ctrl #(
   parameter int ADDR_WIDTH = 5
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       CLEAR_N,
   fifo_ctrl_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_MID   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   use_cnt;
   logic                  ovf;
   logic                  udf;

   logic wr_ok;
   logic rd_ok;
   logic cnt_en;
   logic cnt_up;

   // Accept decisions come from the registered state only. RST_N gates them
   // so the RAM never sees a strobe while the controller is held in reset.
   assign wr_ok  = RST_N & bus.WRITE & (state != S_FULL);
   assign rd_ok  = RST_N & bus.READ  & (state != S_EMPTY);

   // Occupancy counter controls: a simultaneous read and write cancel out.
   assign cnt_en = wr_ok ^ rd_ok;
   assign cnt_up = wr_ok;

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= S_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; the occupancy count decides the MID->FULL/EMPTY edges.
   always_comb begin
      state_nxt = state;
      if (!CLEAR_N) begin
         state_nxt = S_EMPTY;
      end else begin
         case (state)
            S_EMPTY: begin
               if (wr_ok) state_nxt = (DEPTH == 1) ? S_FULL : S_MID;
            end
            S_MID: begin
               if (wr_ok && !rd_ok && (use_cnt == CNT_LAST))
                  state_nxt = S_FULL;
               else if (rd_ok && !wr_ok && (use_cnt == CNT_ONE))
                  state_nxt = S_EMPTY;
            end
            S_FULL: begin
               if (rd_ok) state_nxt = (DEPTH == 1) ? S_EMPTY : S_MID;
            end
            default: state_nxt = S_EMPTY;
         endcase
      end
   end

   // Pointers, occupancy and the one-cycle rejected-request pulses.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         use_cnt <= '0;
         ovf     <= 1'b0;
         udf     <= 1'b0;
      end else if (!CLEAR_N) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         use_cnt <= '0;
         ovf     <= 1'b0;
         udf     <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         if (cnt_en) begin
            use_cnt <= cnt_up ? (use_cnt + 1'b1) : (use_cnt - 1'b1);
         end
         ovf <= bus.WRITE & (state == S_FULL);
         udf <= bus.READ  & (state == S_EMPTY);
      end
   end

   assign bus.RAM_WE    = wr_ok;
   assign bus.RAM_RE    = rd_ok;
   assign bus.RAM_WADDR = wr_ptr;
   assign bus.RAM_RADDR = rd_ptr;
   assign bus.FULL      = (state == S_FULL);
   assign bus.EMPTY     = (state == S_EMPTY);
   assign bus.USE_DW    = use_cnt;
   assign bus.OVERFLOW  = ovf;
   assign bus.UNDERFLOW = udf;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_ctrl
//  Description : Self-checking bench for fifo_ctrl: a vector table, directed
//                corner sequences and random traffic against an occupancy
//                model kept as plain integers.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_ctrl;

   localparam int AW    = 5;
   localparam int DEPTH = 2 ** AW;

   logic CLK;
   logic RST_N;
   logic CLEAR_N;

   fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .CLEAR_N (CLEAR_N),
      .bus     (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: occupancy and pointer positions as integers.
   int m_cnt;
   int m_wp;
   int m_rp;
   bit m_ovf;
   bit m_udf;

   typedef struct {
      bit w;
      bit r;
      bit we;
      bit re;
      int use_dw;
      bit full;
      bit empty;
      bit ovf;
      bit udf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_wp  = 0;
      m_rp  = 0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   // Applies one clock edge to the model using the inputs currently driven.
   task automatic model_step();
      bit we;
      bit re;
      if (!RST_N || !CLEAR_N) begin
         model_reset();
         return;
      end
      we    = bus.WRITE && (m_cnt < DEPTH);
      re    = bus.READ  && (m_cnt > 0);
      m_ovf = bus.WRITE && (m_cnt == DEPTH);
      m_udf = bus.READ  && (m_cnt == 0);
      m_cnt = m_cnt + int'(we) - int'(re);
      m_wp  = (m_wp + int'(we)) % DEPTH;
      m_rp  = (m_rp + int'(re)) % DEPTH;
   endtask

   task automatic check_all();
      chk("ram_we",    bus.RAM_WE,    RST_N && bus.WRITE && (m_cnt < DEPTH));
      chk("ram_re",    bus.RAM_RE,    RST_N && bus.READ  && (m_cnt > 0));
      chk("ram_waddr", bus.RAM_WADDR, m_wp);
      chk("ram_raddr", bus.RAM_RADDR, m_rp);
      chk("use_dw",    bus.USE_DW,    m_cnt);
      chk("full",      bus.FULL,      m_cnt == DEPTH);
      chk("empty",     bus.EMPTY,     m_cnt == 0);
      chk("overflow",  bus.OVERFLOW,  m_ovf);
      chk("underflow", bus.UNDERFLOW, m_udf);
   endtask

   // One clock cycle, entered and left at the falling edge.
   task automatic cycle(input bit w, input bit r);
      bus.WRITE = w;
      bus.READ  = r;
      #1;
      check_all();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RST_N     = 1'b0;
      bus.WRITE = 1'b0;
      bus.READ  = 1'b0;
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST_N     = 1'b0;
      CLEAR_N   = 1'b1;
      bus.WRITE = 1'b0;
      bus.READ  = 1'b0;
      model_reset();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;

      // Reset then idle.
      repeat (3) cycle(1'b0, 1'b0);
      chk("rst_empty", bus.EMPTY, 1);
      chk("rst_full",  bus.FULL, 0);
      chk("rst_use",   bus.USE_DW, 0);
      chk("rst_waddr", bus.RAM_WADDR, 0);
      chk("rst_raddr", bus.RAM_RADDR, 0);

      // Vector table from the empty state: {w, r, we, re, use, full, empty, ovf, udf}.
      vecs.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{0, 1, 0, 0, 0, 0, 1, 0, 1});
      vecs.push_back('{1, 1, 1, 0, 1, 0, 0, 0, 1});
      vecs.push_back('{1, 0, 1, 0, 2, 0, 0, 0, 0});
      vecs.push_back('{1, 1, 1, 1, 2, 0, 0, 0, 0});
      vecs.push_back('{0, 1, 0, 1, 1, 0, 0, 0, 0});
      vecs.push_back('{0, 1, 0, 1, 0, 0, 1, 0, 0});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{0, 1, 0, 0, 0, 0, 1, 0, 1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{1, 0, 1, 0, 1, 0, 0, 0, 0});
      for (int i = 0; i < vecs.size(); i++) begin
         bus.WRITE = vecs[i].w;
         bus.READ  = vecs[i].r;
         #1;
         chk("tbl_we", bus.RAM_WE, vecs[i].we);
         chk("tbl_re", bus.RAM_RE, vecs[i].re);
         @(posedge CLK);
         model_step();
         @(negedge CLK);
         chk("tbl_use",   bus.USE_DW,    vecs[i].use_dw);
         chk("tbl_full",  bus.FULL,      vecs[i].full);
         chk("tbl_empty", bus.EMPTY,     vecs[i].empty);
         chk("tbl_ovf",   bus.OVERFLOW,  vecs[i].ovf);
         chk("tbl_udf",   bus.UNDERFLOW, vecs[i].udf);
      end

      // Fill to full, overflow, drain to empty, underflow.
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         bus.WRITE = 1'b1;
         bus.READ  = 1'b0;
         #1;
         chk("fill_waddr", bus.RAM_WADDR, i);
         chk("fill_we",    bus.RAM_WE, 1);
         @(posedge CLK);
         model_step();
         @(negedge CLK);
         if (i == 0) chk("fill_empty_after_1", bus.EMPTY, 0);
         if (i == DEPTH - 2) chk("fill_full_early", bus.FULL, 0);
      end
      chk("fill_full",  bus.FULL, 1);
      chk("fill_use",   bus.USE_DW, DEPTH);
      chk("fill_wrap",  bus.RAM_WADDR, 0);
      cycle(1'b1, 1'b0);
      chk("ovf_pulse", bus.OVERFLOW, 1);
      chk("ovf_use",   bus.USE_DW, DEPTH);
      cycle(1'b0, 1'b0);
      chk("ovf_clear", bus.OVERFLOW, 0);
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1);
      chk("drain_empty", bus.EMPTY, 1);
      chk("drain_use",   bus.USE_DW, 0);
      cycle(1'b0, 1'b1);
      chk("udf_pulse", bus.UNDERFLOW, 1);
      cycle(1'b0, 1'b0);
      chk("udf_clear", bus.UNDERFLOW, 0);

      // Simultaneous read/write in MID, FULL and EMPTY.
      do_reset();
      repeat (10) cycle(1'b1, 1'b0);
      repeat (40) cycle(1'b1, 1'b1);
      chk("rw_use",   bus.USE_DW, 10);
      chk("rw_waddr", bus.RAM_WADDR, (10 + 40) % DEPTH);
      chk("rw_raddr", bus.RAM_RADDR, 40 % DEPTH);
      repeat (DEPTH - 10) cycle(1'b1, 1'b0);
      chk("rw_full", bus.FULL, 1);
      cycle(1'b1, 1'b1);
      chk("rw_full_use", bus.USE_DW, DEPTH - 1);
      chk("rw_full_ovf", bus.OVERFLOW, 1);
      repeat (DEPTH - 1) cycle(1'b0, 1'b1);
      chk("rw_empty", bus.EMPTY, 1);
      cycle(1'b1, 1'b1);
      chk("rw_empty_use", bus.USE_DW, 1);
      chk("rw_empty_udf", bus.UNDERFLOW, 1);

      // Asynchronous reset between edges.
      do_reset();
      repeat (17) cycle(1'b1, 1'b0);
      bus.WRITE = 1'b1;
      #2;
      RST_N = 1'b0;
      #1;
      chk("arst_use",   bus.USE_DW, 0);
      chk("arst_empty", bus.EMPTY, 1);
      chk("arst_full",  bus.FULL, 0);
      chk("arst_we",    bus.RAM_WE, 0);
      chk("arst_waddr", bus.RAM_WADDR, 0);
      model_reset();
      @(negedge CLK);
      RST_N     = 1'b1;
      bus.WRITE = 1'b0;

      // Synchronous clear with a pending write.
      repeat (17) cycle(1'b1, 1'b0);
      CLEAR_N   = 1'b0;
      bus.WRITE = 1'b1;
      #1;
      chk("clr_use_before", bus.USE_DW, 17);
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      chk("clr_use",   bus.USE_DW, 0);
      chk("clr_empty", bus.EMPTY, 1);
      chk("clr_waddr", bus.RAM_WADDR, 0);
      chk("clr_raddr", bus.RAM_RADDR, 0);
      CLEAR_N   = 1'b1;
      bus.WRITE = 1'b0;

      // Random traffic with phases biased towards filling or draining.
      for (int ph = 0; ph < 8; ph++) begin
         int pw;
         pw = (ph % 2 == 0) ? 80 : 25;
         for (int k = 0; k < 150; k++) begin
            bit w;
            bit r;
            w = ($urandom_range(0, 99) < pw);
            r = ($urandom_range(0, 99) < (105 - pw));
            CLEAR_N = ($urandom_range(0, 199) != 0);
            cycle(w, r);
            CLEAR_N = 1'b1;
         end
      end
      cycle(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
